shift_register_sequencer: RTL and testbench

- Controller that sequences one universal shift register instance (WIDTH-bit, with parallel-load, left-shift and right-shift modes).
- Each accepted command either serialises a parallel word onto a serial output (TX) or deserialises a serial input stream into a parallel word (RX).
- Shift order is MSB-first or LSB-first per command.
- The register has no hold mode, so while idle or stalled the sequencer reloads the register with its own output.

---
 rtl/shift_register_sequencer.sv | 107 ++++++++++
 tb/tb_shift_register_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_sequencer.sv
// Sequencer for an external universal shift register: serialises command words (TX)
// or assembles serial input into words (RX), MSB- or LSB-first per command.
module shift_register_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_rx_i,
  input  logic             cmd_msb_first_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic             ser_out_o,
  output logic             ser_out_valid_o,
  input  logic             ser_out_ready_i,
  output logic             ser_out_last_o,
  input  logic             ser_in_i,
  input  logic             ser_in_valid_i,
  output logic             ser_in_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             sr_reset_o,
  output logic             sr_shift_mode_o,
  output logic             sr_shift_dir_o,
  output logic [WIDTH-1:0] sr_data_in_o,
  output logic             sr_data_in_serial_o,
  input  logic [WIDTH-1:0] sr_q_i
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               rx_q;
  logic               msb_q;
  logic [WIDTH-1:0]   data_q;

  logic in_shift;
  logic last_bit;
  logic tx_fire;
  logic rx_fire;
  logic shift_en;

  assign in_shift = reset_i && (state_q == SHIFT);
  assign last_bit = (bit_cnt_q == LAST_CNT);
  assign tx_fire  = in_shift && !rx_q && ser_out_ready_i;
  assign rx_fire  = in_shift &&  rx_q && ser_in_valid_i;
  assign shift_en = tx_fire || rx_fire;

  // NOTE: all state updates use non-blocking assignments so every register sees
  // pre-edge values; data_q has no reset because it is always written at acceptance
  // before LOAD reads it.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= 1'b0;
      msb_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            rx_q      <= cmd_rx_i;
            msb_q     <= cmd_msb_first_i;
            data_q    <= cmd_data_i;
            bit_cnt_q <= '0;
            state_q   <= cmd_rx_i ? SHIFT : LOAD;
          end
        end
        LOAD: state_q <= SHIFT;
        SHIFT: begin
          if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
            if (last_bit) state_q <= rx_q ? DONE : IDLE;
          end
        end
        DONE: begin
          if (rx_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only, forced low while reset is held.
  assign cmd_ready_o     = reset_i && (state_q == IDLE);
  assign ser_out_valid_o = in_shift && !rx_q;
  assign ser_out_last_o  = ser_out_valid_o && last_bit;
  assign ser_out_o       = msb_q ? sr_q_i[WIDTH-1] : sr_q_i[0];
  assign ser_in_ready_o  = in_shift && rx_q;
  assign rx_valid_o      = reset_i && (state_q == DONE);
  assign rx_data_o       = sr_q_i;

  // The register has no hold mode: any cycle without a shift reloads it, either with
  // the latched TX word in LOAD or with its own contents everywhere else.
  assign sr_reset_o          = ~reset_i;
  assign sr_shift_mode_o     = ~shift_en;
  assign sr_shift_dir_o      = shift_en && !msb_q;
  assign sr_data_in_serial_o = rx_fire && ser_in_i;
  assign sr_data_in_o        = (state_q == LOAD) ? data_q : sr_q_i;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Directed bench for shift_register_sequencer driving a behavioural 4-bit universal
// shift register; table of TX/RX commands plus stall, reset and back-to-back sequences.
module tb_shift_register_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_rx, cmd_msb_first;
  logic [3:0] cmd_data;
  logic       ser_out, ser_out_valid, ser_out_ready, ser_out_last;
  logic       ser_in, ser_in_valid, ser_in_ready;
  logic [3:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       sr_reset, sr_shift_mode, sr_shift_dir, sr_data_in_serial;
  logic [3:0] sr_data_in, sr_q;

  int checks   = 0;
  int errors   = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  shift_register_sequencer #(.WIDTH(4)) dut (
    .clock_i             (clk),
    .reset_i             (reset_n),
    .cmd_valid_i         (cmd_valid),
    .cmd_ready_o         (cmd_ready),
    .cmd_rx_i            (cmd_rx),
    .cmd_msb_first_i     (cmd_msb_first),
    .cmd_data_i          (cmd_data),
    .ser_out_o           (ser_out),
    .ser_out_valid_o     (ser_out_valid),
    .ser_out_ready_i     (ser_out_ready),
    .ser_out_last_o      (ser_out_last),
    .ser_in_i            (ser_in),
    .ser_in_valid_i      (ser_in_valid),
    .ser_in_ready_o      (ser_in_ready),
    .rx_data_o           (rx_data),
    .rx_valid_o          (rx_valid),
    .rx_ready_i          (rx_ready),
    .sr_reset_o          (sr_reset),
    .sr_shift_mode_o     (sr_shift_mode),
    .sr_shift_dir_o      (sr_shift_dir),
    .sr_data_in_o        (sr_data_in),
    .sr_data_in_serial_o (sr_data_in_serial),
    .sr_q_i              (sr_q)
  );

  // Universal shift register: sync clear, parallel load, left/right shift.
  always @(posedge clk) begin
    if (sr_reset)           sr_q <= 4'b0000;
    else if (sr_shift_mode) sr_q <= sr_data_in;
    else if (sr_shift_dir)  sr_q <= {sr_data_in_serial, sr_q[3:1]};
    else                    sr_q <= {sr_q[2:0], sr_data_in_serial};
  end

  always @(posedge clk) begin
    if (ser_out_valid && ser_out_ready) hs_count <= hs_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Starts in the current cycle; ends one cycle after the last handshake.
  task automatic tx_run(input logic msb, input logic [3:0] data, input logic [3:0] exp_stream,
                        input int stall_at, input int stall_len, input logic hold_valid,
                        input logic [3:0] stall_q);
    int hs0;
    cmd_valid = 1'b1; cmd_rx = 1'b0; cmd_msb_first = msb; cmd_data = data;
    settle();
    check_bit("tx_accept_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = hold_valid; cmd_data = ~data; cmd_msb_first = ~msb;
    ser_out_ready = 1'b0; ser_in_valid = 1'b1; ser_in = 1'b1;
    settle();
    check_bit("tx_load_mode", sr_shift_mode, 1'b1);
    check_word("tx_load_data", sr_data_in, data);
    check_bit("tx_load_valid", ser_out_valid, 1'b0);
    check_bit("tx_load_cmd_ready", cmd_ready, 1'b0);
    step();
    hs0 = hs_count;
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          ser_out_ready = 1'b0;
          settle();
          check_bit("tx_stall_valid", ser_out_valid, 1'b1);
          check_bit("tx_stall_bit", ser_out, exp_stream[3-i]);
          check_bit("tx_stall_mode", sr_shift_mode, 1'b1);
          check_word("tx_stall_q", sr_q, stall_q);
          step();
        end
      end
      ser_out_ready = 1'b1;
      settle();
      check_bit("tx_valid", ser_out_valid, 1'b1);
      check_bit("tx_bit", ser_out, exp_stream[3-i]);
      check_bit("tx_last", ser_out_last, (i == 3));
      check_bit("tx_dir", sr_shift_dir, ~msb);
      check_bit("tx_mode", sr_shift_mode, 1'b0);
      check_bit("tx_busy_cmd_ready", cmd_ready, 1'b0);
      step();
    end
    ser_out_ready = 1'b0; ser_in_valid = 1'b0; ser_in = 1'b0;
    if (!hold_valid) cmd_valid = 1'b0;
    settle();
    check_bit("tx_end_cmd_ready", cmd_ready, 1'b1);
    check_bit("tx_end_valid", ser_out_valid, 1'b0);
    check_word("tx_end_sr_q", sr_q, 4'b0000);
    check_word("tx_handshakes", 4'(hs_count - hs0), 4'd4);
  endtask

  // bits holds the serial stream with the first bit in [3].
  task automatic rx_run(input logic msb, input logic [3:0] bits, input logic [3:0] exp,
                        input int gap_at, input int gap_len, input int rdy_delay);
    cmd_valid = 1'b1; cmd_rx = 1'b1; cmd_msb_first = msb; cmd_data = 4'b1111;
    settle();
    check_bit("rx_accept_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0; cmd_rx = 1'b0; cmd_msb_first = ~msb; ser_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          ser_in_valid = 1'b0; ser_in = ~bits[3-i];
          settle();
          check_bit("rx_gap_ready", ser_in_ready, 1'b1);
          check_bit("rx_gap_mode", sr_shift_mode, 1'b1);
          check_bit("rx_gap_rx_valid", rx_valid, 1'b0);
          step();
        end
      end
      ser_in_valid = 1'b1; ser_in = bits[3-i];
      settle();
      check_bit("rx_in_ready", ser_in_ready, 1'b1);
      check_bit("rx_no_tx_valid", ser_out_valid, 1'b0);
      check_bit("rx_serial", sr_data_in_serial, bits[3-i]);
      check_bit("rx_dir", sr_shift_dir, ~msb);
      step();
    end
    ser_in_valid = 1'b0; ser_in = 1'b1;
    for (int d = 0; d < rdy_delay; d++) begin
      rx_ready = 1'b0;
      settle();
      check_bit("rx_wait_valid", rx_valid, 1'b1);
      check_word("rx_wait_data", rx_data, exp);
      check_bit("rx_wait_in_ready", ser_in_ready, 1'b0);
      step();
    end
    rx_ready = 1'b1;
    settle();
    check_bit("rx_valid", rx_valid, 1'b1);
    check_word("rx_data", rx_data, exp);
    step();
    rx_ready = 1'b0; ser_out_ready = 1'b0;
    settle();
    check_bit("rx_end_cmd_ready", cmd_ready, 1'b1);
    check_bit("rx_end_valid", rx_valid, 1'b0);
  endtask

  typedef struct {
    logic       rx;
    logic       msb;
    logic [3:0] word;
    logic [3:0] expect_val;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // TX: word -> stream (first bit in [3]); RX: stream -> word.
    vecs[0] = '{rx: 1'b0, msb: 1'b1, word: 4'b1011, expect_val: 4'b1011};
    vecs[1] = '{rx: 1'b0, msb: 1'b0, word: 4'b1011, expect_val: 4'b1101};
    vecs[2] = '{rx: 1'b0, msb: 1'b1, word: 4'b0110, expect_val: 4'b0110};
    vecs[3] = '{rx: 1'b0, msb: 1'b0, word: 4'b1000, expect_val: 4'b0001};
    vecs[4] = '{rx: 1'b1, msb: 1'b1, word: 4'b1100, expect_val: 4'b1100};
    vecs[5] = '{rx: 1'b1, msb: 1'b0, word: 4'b1100, expect_val: 4'b0011};
    vecs[6] = '{rx: 1'b1, msb: 1'b0, word: 4'b1000, expect_val: 4'b0001};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_rx = 1'b0; cmd_msb_first = 1'b0; cmd_data = 4'b0000;
    ser_out_ready = 1'b0; ser_in = 1'b0; ser_in_valid = 1'b0; rx_ready = 1'b0;
    step();
    step();
    check_bit("rst_cmd_ready", cmd_ready, 1'b0);
    check_bit("rst_ser_out_valid", ser_out_valid, 1'b0);
    check_bit("rst_ser_in_ready", ser_in_ready, 1'b0);
    check_bit("rst_rx_valid", rx_valid, 1'b0);
    check_bit("rst_ser_out_last", ser_out_last, 1'b0);
    check_bit("rst_sr_reset", sr_reset, 1'b1);
    check_word("rst_sr_q", sr_q, 4'b0000);
    reset_n = 1'b1;
    settle();
    check_bit("post_rst_sr_reset", sr_reset, 1'b0);
    check_bit("post_rst_cmd_ready", cmd_ready, 1'b1);
    step();
    check_word("idle_hold_sr_q", sr_q, 4'b0000);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rx) rx_run(vecs[v].msb, vecs[v].word, vecs[v].expect_val, -1, 0, 0);
      else tx_run(vecs[v].msb, vecs[v].word, vecs[v].expect_val, -1, 0, 1'b0, 4'b0000);
    end

    // TX with the consumer stalling three cycles after the second bit.
    tx_run(1'b1, 4'b1100, 4'b1100, 2, 3, 1'b0, 4'b0000);

    // RX with input gaps and a slow consumer, both bit orders.
    rx_run(1'b1, 4'b1100, 4'b1100, 2, 2, 2);
    rx_run(1'b0, 4'b1100, 4'b0011, 2, 2, 2);

    // Reset pulse during TX bit 2 aborts the word.
    cmd_valid = 1'b1; cmd_rx = 1'b0; cmd_msb_first = 1'b1; cmd_data = 4'b1011;
    step();
    cmd_valid = 1'b0;
    step();
    ser_out_ready = 1'b1;
    settle();
    check_bit("abort_bit1", ser_out, 1'b1);
    step();
    reset_n = 1'b0;
    settle();
    check_bit("abort_rst_valid", ser_out_valid, 1'b0);
    check_bit("abort_rst_last", ser_out_last, 1'b0);
    check_bit("abort_rst_cmd_ready", cmd_ready, 1'b0);
    check_bit("abort_rst_sr_reset", sr_reset, 1'b1);
    step();
    reset_n = 1'b1; ser_out_ready = 1'b0;
    settle();
    check_bit("abort_idle_valid", ser_out_valid, 1'b0);
    check_word("abort_sr_q", sr_q, 4'b0000);
    check_bit("abort_cmd_ready", cmd_ready, 1'b1);
    tx_run(1'b1, 4'b0110, 4'b0110, -1, 0, 1'b0, 4'b0000);

    // cmd_valid held high through a TX, then an RX accepted back-to-back.
    tx_run(1'b1, 4'b1011, 4'b1011, -1, 0, 1'b1, 4'b0000);
    rx_run(1'b0, 4'b1010, 4'b0101, -1, 0, 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
